// File: rtl/dual_port_ram_clr.sv
// dual_port_ram_clr: parametrised true dual-port synchronous RAM with a
// post-reset clear sequencer, collision arbitration (port A wins) and a
// selectable read-during-write mode.
// Optional feature macro: DPRAM_PARITY_EN (per-word even parity + perr_x).
module dual_port_ram_clr #(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 6,
   parameter int                DEPTH    = 1 << ADDR_W,
   parameter int                RDW_MODE = 0,
   parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              init_busy,
   input  logic              en_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] data_a,
   output logic [DATA_W-1:0] q_a,
   input  logic              en_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] data_b,
   output logic [DATA_W-1:0] q_b,
   output logic              collision,
   output logic              perr_a,
   output logic              perr_b
);

`ifdef DPRAM_PARITY_EN
   localparam int MW = DATA_W + 1;
`else
   localparam int MW = DATA_W;
`endif

   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_INIT, S_READY} state_t;

   // Stored word: parity bit (when enabled) above the data bits
   function automatic logic [MW-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef DPRAM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   logic [MW-1:0]     mem_q [DEPTH];
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] q_a_q, q_a_d, q_b_q, q_b_d;
   logic              coll_q, coll_d;
   logic              ready, in_a, in_b, same, wr_a, wr_b;
   logic [MW-1:0]     word_a, word_b;

   assign ready = (state_q == S_READY);
   assign in_a  = ({1'b0, addr_a} < DEPTH_L);
   assign in_b  = ({1'b0, addr_b} < DEPTH_L);
   assign same  = (addr_a == addr_b);
   assign wr_a  = ready & en_a & we_a & in_a;
   // Port B loses a same-address write to port A
   assign wr_b  = ready & en_b & we_b & in_b & ~(wr_a & same);

   // State/counter register; reset restarts the clear from address 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Clear sequencer: one word per edge, READY after the last word
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d = S_READY;
            cnt_d   = '0;
         end
      end
   end

   // Array write: clear in INIT, port writes in READY
   always_ff @(posedge clk) begin
      if (state_q == S_INIT) begin
         mem_q[cnt_q] <= enc(CLR_VAL);
      end else begin
         if (wr_a) mem_q[addr_a] <= enc(data_a);
         if (wr_b) mem_q[addr_b] <= enc(data_b);
      end
   end

   // Read word selection; write-first forwards the stored (winning) data
   always_comb begin
      word_a = '0;
      word_b = '0;
      if (in_a) begin
         word_a = mem_q[addr_a];
         if (RDW_MODE != 0) begin
            if (wr_a)              word_a = enc(data_a);
            else if (wr_b && same) word_a = enc(data_b);
         end
      end
      if (in_b) begin
         word_b = mem_q[addr_b];
         if (RDW_MODE != 0) begin
            if (wr_a && same) word_b = enc(data_a);
            else if (wr_b)    word_b = enc(data_b);
         end
      end
   end

   // Next read data and collision flag; everything held at 0 during INIT
   always_comb begin
      q_a_d  = q_a_q;
      q_b_d  = q_b_q;
      coll_d = 1'b0;
      if (!ready) begin
         q_a_d = '0;
         q_b_d = '0;
      end else begin
         if (en_a) q_a_d = word_a[DATA_W-1:0];
         if (en_b) q_b_d = word_b[DATA_W-1:0];
         coll_d = wr_a & en_b & we_b & in_b & same;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_a_q  <= '0;
         q_b_q  <= '0;
         coll_q <= 1'b0;
      end else begin
         q_a_q  <= q_a_d;
         q_b_q  <= q_b_d;
         coll_q <= coll_d;
      end
   end

   assign q_a       = q_a_q;
   assign q_b       = q_b_q;
   assign collision = coll_q;
   assign init_busy = ~ready;

`ifdef DPRAM_PARITY_EN
   logic perr_a_q, perr_a_d, perr_b_q, perr_b_d;

   // Parity check of the word being read; out-of-range reads are all-zero words
   always_comb begin
      perr_a_d = perr_a_q;
      perr_b_d = perr_b_q;
      if (!ready) begin
         perr_a_d = 1'b0;
         perr_b_d = 1'b0;
      end else begin
         if (en_a) perr_a_d = ^word_a;
         if (en_b) perr_b_d = ^word_b;
      end
   end

   // Parity error registers, aligned with q_x
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_a_q <= 1'b0;
         perr_b_q <= 1'b0;
      end else begin
         perr_a_q <= perr_a_d;
         perr_b_q <= perr_b_d;
      end
   end

   assign perr_a = perr_a_q;
   assign perr_b = perr_b_q;
`else
   assign perr_a = 1'b0;
   assign perr_b = 1'b0;
`endif

endmodule

// File: tb/tb_dual_port_ram_clr.sv
// Directed bench for dual_port_ram_clr: u0 is full-depth read-first,
// u1 is DEPTH=48 write-first; both share the same port stimulus.
module tb_dual_port_ram_clr;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en_a = 0, we_a = 0, en_b = 0, we_b = 0;
   logic [5:0] addr_a = 0, addr_b = 0;
   logic [7:0] data_a = 0, data_b = 0;
   logic [7:0] q_a0, q_b0, q_a1, q_b1;
   logic       busy0, busy1, coll0, coll1, pa0, pb0, pa1, pb1;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   dual_port_ram_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .RDW_MODE(0), .CLR_VAL(8'h00)) u0 (
      .clk(clk), .rst_n(rst_n), .init_busy(busy0),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a0),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b0),
      .collision(coll0), .perr_a(pa0), .perr_b(pb0));

   dual_port_ram_clr #(.DATA_W(8), .ADDR_W(6), .DEPTH(48), .RDW_MODE(1), .CLR_VAL(8'h00)) u1 (
      .clk(clk), .rst_n(rst_n), .init_busy(busy1),
      .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a1),
      .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b1),
      .collision(coll1), .perr_a(pa1), .perr_b(pb1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en_a = 0; we_a = 0; en_b = 0; we_b = 0;
   endtask

   task automatic port_a(input logic en, input logic we, input logic [5:0] ad, input logic [7:0] d);
      en_a = en; we_a = we; addr_a = ad; data_a = d;
   endtask

   task automatic port_b(input logic en, input logic we, input logic [5:0] ad, input logic [7:0] d);
      en_b = en; we_b = we; addr_b = ad; data_b = d;
   endtask

   // Count edges until each instance leaves INIT; port writes attempted early must be ignored
   task automatic wait_init(input int exp0, input int exp1);
      int n0, n1;
      n0 = -1; n1 = -1;
      port_a(1, 1, 6'd0, 8'hFF);
      port_b(1, 1, 6'd1, 8'hEE);
      for (int i = 1; i <= 80; i++) begin
         step();
         if (i == 10) begin
            checks++; if (q_a0 !== 8'h00 || coll0 !== 1'b0) begin errors++; $display("FAIL init_mask q_a0=%h coll0=%b required 00/0", q_a0, coll0); end
         end
         if (i == 20) idle();
         if (n0 < 0 && busy0 === 1'b0) n0 = i;
         if (n1 < 0 && busy1 === 1'b0) n1 = i;
         if (n0 >= 0 && n1 >= 0) break;
      end
      checks++; if (n0 != exp0) begin errors++; $display("FAIL init_len0 edges=%0d required %0d", n0, exp0); end
      checks++; if (n1 != exp1) begin errors++; $display("FAIL init_len1 edges=%0d required %0d", n1, exp1); end
      idle();
   endtask

   task automatic test_reset();
      rst_n = 0;
      #2;
      checks++; if (q_a0 !== 8'h00 || q_b0 !== 8'h00 || coll0 !== 1'b0 || busy0 !== 1'b1 || pa0 !== 1'b0 || pb0 !== 1'b0)
         begin errors++; $display("FAIL reset_state q_a=%h q_b=%h coll=%b busy=%b required 00 00 0 1", q_a0, q_b0, coll0, busy0); end
      step(); step();
      rst_n = 1;
      wait_init(64, 48);
   endtask

   // Every address reads back CLR_VAL; u1 reads beyond DEPTH return 0
   task automatic test_clear_read();
      for (int i = 0; i < 64; i++) begin
         port_a(1, 0, 6'(i), 8'h00);
         port_b(1, 0, 6'(63 - i), 8'h00);
         step();
         checks++; if (q_a0 !== 8'h00 || q_b0 !== 8'h00 || q_a1 !== 8'h00 || q_b1 !== 8'h00 || pa0 !== 1'b0)
            begin errors++; $display("FAIL clear_read addr=%0d q=%h %h %h %h required 00", i, q_a0, q_b0, q_a1, q_b1); end
      end
      idle();
   endtask

   task automatic test_basic();
      port_a(1, 1, 6'd1, 8'h01); port_b(1, 1, 6'd2, 8'h02); step();
      port_a(1, 0, 6'd2, 8'h00); port_b(1, 0, 6'd1, 8'h00); step();
      checks++; if (q_a0 !== 8'h02 || q_b0 !== 8'h01) begin errors++; $display("FAIL basic_u0 q_a=%h q_b=%h required 02 01", q_a0, q_b0); end
      checks++; if (q_a1 !== 8'h02 || q_b1 !== 8'h01) begin errors++; $display("FAIL basic_u1 q_a=%h q_b=%h required 02 01", q_a1, q_b1); end
      // Disabled ports hold their read data
      idle(); port_a(0, 0, 6'd1, 8'h00); step();
      checks++; if (q_a0 !== 8'h02 || q_b1 !== 8'h01) begin errors++; $display("FAIL hold q_a0=%h q_b1=%h required 02 01", q_a0, q_b1); end
   endtask

   task automatic test_rdw();
      port_a(1, 1, 6'd5, 8'h11); step();
      port_a(1, 1, 6'd5, 8'h22); port_b(1, 0, 6'd5, 8'h00); step();
      checks++; if (q_b0 !== 8'h11 || q_a0 !== 8'h11) begin errors++; $display("FAIL rdw_old q_b0=%h q_a0=%h required 11 11", q_b0, q_a0); end
      checks++; if (q_b1 !== 8'h22 || q_a1 !== 8'h22) begin errors++; $display("FAIL rdw_new q_b1=%h q_a1=%h required 22 22", q_b1, q_a1); end
      checks++; if (coll0 !== 1'b0) begin errors++; $display("FAIL rdw_nocoll coll0=%b required 0", coll0); end
      port_b(1, 1, 6'd5, 8'h33); port_a(1, 0, 6'd5, 8'h00); step();
      checks++; if (q_a0 !== 8'h22 || q_a1 !== 8'h33) begin errors++; $display("FAIL rdw_b_wr q_a0=%h q_a1=%h required 22 33", q_a0, q_a1); end
      idle();
   endtask

   task automatic test_collision();
      port_a(1, 1, 6'd7, 8'hAA); port_b(1, 1, 6'd7, 8'h55); step();
      checks++; if (coll0 !== 1'b1 || coll1 !== 1'b1) begin errors++; $display("FAIL coll_pulse coll=%b %b required 1 1", coll0, coll1); end
      checks++; if (q_a0 !== 8'h00 || q_b0 !== 8'h00 || q_a1 !== 8'hAA || q_b1 !== 8'hAA)
         begin errors++; $display("FAIL coll_q q=%h %h %h %h required 00 00 aa aa", q_a0, q_b0, q_a1, q_b1); end
      idle(); step();
      checks++; if (coll0 !== 1'b0 || coll1 !== 1'b0) begin errors++; $display("FAIL coll_one_cycle coll=%b %b required 0 0", coll0, coll1); end
      port_a(1, 0, 6'd7, 8'h00); port_b(1, 0, 6'd7, 8'h00); step();
      checks++; if (q_a0 !== 8'hAA || q_b1 !== 8'hAA) begin errors++; $display("FAIL coll_store q_a0=%h q_b1=%h required aa aa", q_a0, q_b1); end
      port_a(1, 1, 6'd10, 8'h10); port_b(1, 1, 6'd11, 8'h11); step();
      checks++; if (coll0 !== 1'b0) begin errors++; $display("FAIL coll_diff coll0=%b required 0", coll0); end
      idle();
   endtask

   // addr 50 is in range for u0 and out of range for u1
   task automatic test_oob();
      port_a(1, 1, 6'd50, 8'h5A); port_b(1, 1, 6'd50, 8'hA5); step();
      checks++; if (coll0 !== 1'b1 || coll1 !== 1'b0) begin errors++; $display("FAIL oob_coll coll=%b %b required 1 0", coll0, coll1); end
      port_a(1, 0, 6'd50, 8'h00); port_b(1, 0, 6'd50, 8'h00); step();
      checks++; if (q_a0 !== 8'h5A || q_a1 !== 8'h00 || q_b1 !== 8'h00) begin errors++; $display("FAIL oob_read q_a0=%h q_a1=%h q_b1=%h required 5a 00 00", q_a0, q_a1, q_b1); end
      idle();
   endtask

   task automatic test_reset_mid();
      port_a(1, 1, 6'd9, 8'h3C); step();
      port_a(1, 0, 6'd9, 8'h00); step();
      checks++; if (q_a0 !== 8'h3C || q_a1 !== 8'h3C) begin errors++; $display("FAIL mid_pre q_a=%h %h required 3c 3c", q_a0, q_a1); end
      port_a(1, 1, 6'd9, 8'h77);
      #2 rst_n = 0;
      #1;
      checks++; if (q_a0 !== 8'h00 || busy0 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL mid_async q_a0=%h busy=%b %b required 00 1 1", q_a0, busy0, busy1); end
      idle();
      step(); step();
      rst_n = 1;
      wait_init(64, 48);
      port_a(1, 0, 6'd9, 8'h00); port_b(1, 0, 6'd0, 8'h00); step();
      checks++; if (q_a0 !== 8'h00 || q_a1 !== 8'h00 || q_b0 !== 8'h00) begin errors++; $display("FAIL mid_cleared q=%h %h %h required 00", q_a0, q_a1, q_b0); end
      idle();
   endtask

`ifdef DPRAM_PARITY_EN
   task automatic test_parity();
      port_a(1, 1, 6'd3, 8'h0F); port_b(1, 1, 6'd4, 8'h0F); step();
      idle(); step();
      u0.mem_q[3][0] = ~u0.mem_q[3][0];
      port_a(1, 0, 6'd3, 8'h00); step();
      checks++; if (pa0 !== 1'b1 || q_a0 !== 8'h0E) begin errors++; $display("FAIL parity_err perr=%b q=%h required 1 0e", pa0, q_a0); end
      port_a(1, 0, 6'd4, 8'h00); step();
      checks++; if (pa0 !== 1'b0 || q_a0 !== 8'h0F) begin errors++; $display("FAIL parity_clean perr=%b q=%h required 0 0f", pa0, q_a0); end
      idle();
   endtask
`endif

   initial begin
      test_reset();
      test_clear_read();
      test_basic();
      test_rdw();
      test_collision();
      test_oob();
      test_reset_mid();
`ifdef DPRAM_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
